mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly downstream of EX.
- Takes EX/MEM operands, runs load/store transactions on a req/gnt/rvalid data-memory port, and generates byte enables and store-data lane replication.
- Sign- or zero-extends load data, stalls upstream while a transaction is outstanding, and drives the registered MEM/WB outputs.

Parameters:
XLEN, 32, data width
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset
ex_valid_i  in  1  EX/MEM holds a valid instruction
ex_mem_read_i  in  1  load
ex_mem_write_i  in  1  store (never asserted together with ex_mem_read_i)
ex_funct3_i  in  3  load/store funct3
ex_alu_result_i  in  XLEN  ALU result; the byte address for loads/stores
ex_store_data_i  in  XLEN  rs2 value
ex_rd_i  in  5  destination register
ex_reg_write_i  in  1  register write enable
stall_o  out  1  hold EX/MEM; an instruction is consumed when ex_valid_i=1 and stall_o=0
dmem_req_o  out  1  request
dmem_we_o  out  1  write
dmem_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  XLEN  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  XLEN  load data
wb_valid_o  out  1  MEM/WB valid
wb_rd_o  out  5  destination register
wb_reg_write_o  out  1  write enable
wb_data_o  out  XLEN  writeback data
lsu_err_o  out  1  one-cycle error pulse (misaligned or illegal funct3)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM goes to IDLE.
  - All outputs are 0, including dmem_req_o and stall_o; this takes effect immediately.
  - An rvalid arriving after a mid-transaction reset is ignored.
- FSM has three states:
  - IDLE: accepting new instructions.
  - REQ: dmem_req_o=1; req, we, addr, be and wdata come from captured registers and stay stable until gnt.
  - WAIT: load only, waiting for rvalid.
- IDLE, non-memory instruction:
  - Consumed the same cycle (stall_o=0).
  - Next cycle: wb_valid_o=1, wb_data_o=ex_alu_result_i, with rd and reg_write passed through.
- IDLE, memory op, legal and aligned:
  - Capture the op, stall_o=1, go to REQ.
- IDLE, memory op, misaligned or illegal:
  - Misaligned: LH, LHU or SH with addr[0]=1; LW or SW with addr[1:0]!=0.
  - Illegal: load funct3 of 011, 110 or 111; store funct3 > 010.
  - No request is issued. Consumed in one cycle.
  - Next cycle: lsu_err_o=1, wb_valid_o=1, wb_reg_write_o=0.
- REQ: stall_o=1.
  - gnt with a store: stall_o=0 this cycle (consumed), go to IDLE. Next cycle wb_valid_o=1, wb_reg_write_o=0.
  - gnt with a load: go to WAIT.
- WAIT: stall_o=1 until rvalid.
  - rvalid: stall_o=0 (consumed), go to IDLE. Next cycle wb_valid_o=1 with extracted data.
  - rvalid is never sampled in the gnt cycle; it is valid at earliest one cycle after gnt.
- Store byte enables and data:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111.
- Loads: be follows the same rules with we=0.
- Load extraction: select the byte at addr[1:0] or the half at addr[1].
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Pulse outputs: wb_valid_o and lsu_err_o are high for exactly one cycle per consumed instruction.
  - With ex_valid_i=0 in IDLE, wb_valid_o=0 and the wb fields hold their previous values.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Store with immediate gnt: 2 cycles to wb_valid_o.
  - Load with immediate gnt and rvalid the next cycle: 3 cycles to wb_valid_o.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entering REQ and increments in REQ and WAIT.
  - Reaching TIMEOUT_CYCLES aborts the transaction: dmem_req_o drops, stall_o=0 (consumed), go to IDLE.
  - Next cycle: lsu_err_o=1, wb_valid_o=1, wb_reg_write_o=0.
- LSU_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely.

Test Plan:
- ADD result 0x1234, rd=5, reg_write=1 -> next cycle wb_valid_o=1, wb_data_o=0x00001234, wb_rd_o=5; stall_o never asserts.
- SB addr=0x103, rs2=0xAABBCCDD, gnt on first REQ cycle -> dmem_addr_o=0x100, be=4'b1000, wdata=0xDDDDDDDD, we=1; wb_valid_o 2 cycles after issue with wb_reg_write_o=0.
- LB addr=0x202, rdata=0x00800000 -> wb_data_o=0xFFFFFF80; LBU at the same address -> 0x00000080; LH addr=0x202, rdata=0x80010000 -> 0xFFFF8001.
- LW addr=0x301 -> no dmem_req_o; lsu_err_o pulses one cycle later; wb_reg_write_o=0.
- LW with gnt withheld 3 cycles and rvalid 2 cycles after gnt -> req/addr stable throughout, stall_o high until the rvalid cycle, exactly one wb_valid_o.
- rst_n low while in WAIT -> dmem_req_o=0 and stall_o=0 immediately; a later rvalid produces no wb_valid_o; LSU_TIMEOUT_EN with gnt never arriving -> abort after 255 cycles with lsu_err_o.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// RV32I MEM stage: load/store unit on a req/gnt/rvalid data port, with registered MEM/WB outputs.
// Build option: define LSU_TIMEOUT_EN to abort a transaction stuck for TIMEOUT_CYCLES cycles.
module mem_stage_lsu #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_mem_write_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [XLEN-1:0]       ex_alu_result_i,
  input  logic [XLEN-1:0]       ex_store_data_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  ex_reg_write_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic                  wb_reg_write_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic                  lsu_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TMO_W   = (TMO_RAW > 8) ? TMO_RAW : 8;

  logic [1:0]            state_q, state_d;
  logic                  stall_c;
  logic                  cap_c;
  logic                  tmo_hit_c;

  // Captured transaction
  logic                  req_we_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [3:0]            req_be_q;
  logic [XLEN-1:0]       req_wdata_q;
  logic [2:0]            op_f3_q;
  logic [1:0]            op_off_q;
  logic [4:0]            op_rd_q;
  logic                  op_rw_q;

  // MEM/WB registers
  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic                  wb_rw_q, wb_rw_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  wb_err_q, wb_err_d;

  // EX-side decode
  logic                  is_mem_c;
  logic                  illegal_c;
  logic                  misalign_c;
  logic [3:0]            be_c;
  logic [XLEN-1:0]       wdata_c;
  logic [7:0]            ld_byte_c;
  logic [15:0]           ld_half_c;
  logic [XLEN-1:0]       load_data_c;

  assign is_mem_c = ex_mem_read_i | ex_mem_write_i;

  // Legality, alignment and store lane generation for the instruction in EX/MEM
  always_comb begin
    illegal_c  = 1'b0;
    misalign_c = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = ex_store_data_i;
    if (ex_mem_read_i) begin
      illegal_c = (ex_funct3_i == 3'b011) || (ex_funct3_i[2:1] == 2'b11);
    end else if (ex_mem_write_i) begin
      illegal_c = (ex_funct3_i > F3_W);
    end
    case (ex_funct3_i[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ex_alu_result_i[1:0];
        wdata_c = XLEN'({4{ex_store_data_i[7:0]}});
      end
      2'b01: begin
        misalign_c = ex_alu_result_i[0];
        be_c       = ex_alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_c    = XLEN'({2{ex_store_data_i[15:0]}});
      end
      default: begin
        misalign_c = |ex_alu_result_i[1:0];
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    case (op_off_q)
      2'd0:    ld_byte_c = dmem_rdata_i[7:0];
      2'd1:    ld_byte_c = dmem_rdata_i[15:8];
      2'd2:    ld_byte_c = dmem_rdata_i[23:16];
      default: ld_byte_c = dmem_rdata_i[31:24];
    endcase
    ld_half_c = op_off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (op_f3_q)
      F3_B:    load_data_c = {{(XLEN-8){ld_byte_c[7]}}, ld_byte_c};
      F3_BU:   load_data_c = {{(XLEN-8){1'b0}}, ld_byte_c};
      F3_H:    load_data_c = {{(XLEN-16){ld_half_c[15]}}, ld_half_c};
      F3_HU:   load_data_c = {{(XLEN-16){1'b0}}, ld_half_c};
      default: load_data_c = dmem_rdata_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;

  // Cycles spent in REQ/WAIT for the current transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (cap_c) begin
      tmo_cnt_q <= '0;
    end else if (state_q != S_IDLE) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_hit_c = (state_q != S_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_W'(TIMEOUT_CYCLES);
  assign tmo_hit_c  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and MEM/WB next values
  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    cap_c      = 1'b0;
    wb_valid_d = 1'b0;
    wb_err_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_rw_d    = wb_rw_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          if (is_mem_c && !illegal_c && !misalign_c) begin
            stall_c = 1'b1;
            cap_c   = 1'b1;
            state_d = S_REQ;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd_i;
            if (is_mem_c) begin
              wb_err_d  = 1'b1;
              wb_rw_d   = 1'b0;
              wb_data_d = '0;
            end else begin
              wb_rw_d   = ex_reg_write_i;
              wb_data_d = ex_alu_result_i;
            end
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (dmem_gnt_i) begin
          if (req_we_q) begin
            stall_c    = 1'b0;
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = op_rd_q;
            wb_rw_d    = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end else if (tmo_hit_c) begin
          stall_c    = 1'b0;
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_rd_d    = op_rd_q;
          wb_rw_d    = 1'b0;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (dmem_rvalid_i) begin
          stall_c    = 1'b0;
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = op_rd_q;
          wb_rw_d    = op_rw_q;
          wb_data_d  = load_data_c;
        end else if (tmo_hit_c) begin
          stall_c    = 1'b0;
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_rd_d    = op_rd_q;
          wb_rw_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Transaction capture on acceptance of a legal memory op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_be_q    <= '0;
      req_wdata_q <= '0;
      op_f3_q     <= '0;
      op_off_q    <= '0;
      op_rd_q     <= '0;
      op_rw_q     <= 1'b0;
    end else if (cap_c) begin
      req_we_q    <= ex_mem_write_i;
      req_addr_q  <= {ex_alu_result_i[ADDR_WIDTH-1:2], 2'b00};
      req_be_q    <= be_c;
      req_wdata_q <= ex_mem_write_i ? wdata_c : '0;
      op_f3_q     <= ex_funct3_i;
      op_off_q    <= ex_alu_result_i[1:0];
      op_rd_q     <= ex_rd_i;
      op_rw_q     <= ex_reg_write_i & ex_mem_read_i;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
    end
  end

  // Stall must release in the same cycle as gnt/rvalid, and drop at once under reset
  assign stall_o        = rst_n & stall_c;
  assign dmem_req_o     = (state_q == S_REQ);
  assign dmem_we_o      = req_we_q;
  assign dmem_addr_o    = req_addr_q;
  assign dmem_be_o      = req_be_q;
  assign dmem_wdata_o   = req_wdata_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_reg_write_o = wb_rw_q;
  assign wb_data_o      = wb_data_q;
  assign lsu_err_o      = wb_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu; timeout abort is exercised when LSU_TIMEOUT_EN is defined.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_mem_read_i, ex_mem_write_i, ex_reg_write_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_alu_result_i, ex_store_data_i;
  logic [4:0]  ex_rd_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_reg_write_o, lsu_err_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  int checks   = 0;
  int failures = 0;
  int wbv_cnt  = 0;
  int wbv_base;

  mem_stage_lsu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid_i      (ex_valid_i),
    .ex_mem_read_i   (ex_mem_read_i),
    .ex_mem_write_i  (ex_mem_write_i),
    .ex_funct3_i     (ex_funct3_i),
    .ex_alu_result_i (ex_alu_result_i),
    .ex_store_data_i (ex_store_data_i),
    .ex_rd_i         (ex_rd_i),
    .ex_reg_write_i  (ex_reg_write_i),
    .stall_o         (stall_o),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_gnt_i      (dmem_gnt_i),
    .dmem_rvalid_i   (dmem_rvalid_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .wb_valid_o      (wb_valid_o),
    .wb_rd_o         (wb_rd_o),
    .wb_reg_write_o  (wb_reg_write_o),
    .wb_data_o       (wb_data_o),
    .lsu_err_o       (lsu_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wb_valid_o) wbv_cnt <= wbv_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid_i      = 1'b0;
    ex_mem_read_i   = 1'b0;
    ex_mem_write_i  = 1'b0;
    ex_funct3_i     = 3'b000;
    ex_alu_result_i = 32'h0;
    ex_store_data_i = 32'h0;
    ex_rd_i         = 5'd0;
    ex_reg_write_i  = 1'b0;
    dmem_gnt_i      = 1'b0;
    dmem_rvalid_i   = 1'b0;
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd);
    ex_valid_i      = 1'b1;
    ex_mem_read_i   = rd_op;
    ex_mem_write_i  = wr_op;
    ex_funct3_i     = f3;
    ex_alu_result_i = addr;
    ex_store_data_i = rs2;
    ex_rd_i         = rd;
    ex_reg_write_i  = rd_op;
  endtask

  // Store with gnt on the first REQ cycle
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b0, 1'b1, f3, addr, rs2, 5'd0);
    #1 check_eq({tag, "_stall_t0"}, 32'(stall_o), 32'd1);
    step();
    check_eq({tag, "_req"},   32'(dmem_req_o), 32'd1);
    check_eq({tag, "_we"},    32'(dmem_we_o), 32'd1);
    check_eq({tag, "_addr"},  dmem_addr_o, {addr[31:2], 2'b00});
    check_eq({tag, "_be"},    32'(dmem_be_o), 32'(exp_be));
    check_eq({tag, "_wdata"}, dmem_wdata_o, exp_wd);
    dmem_gnt_i = 1'b1;
    #1 check_eq({tag, "_stall_gnt"}, 32'(stall_o), 32'd0);
    step();
    drive_idle();
    check_eq({tag, "_wbv"}, 32'(wb_valid_o), 32'd1);
    check_eq({tag, "_wbrw"}, 32'(wb_reg_write_o), 32'd0);
    check_eq({tag, "_err"}, 32'(lsu_err_o), 32'd0);
  endtask

  // Load with gnt on the first REQ cycle and rvalid the cycle after
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, addr, 32'h0, 5'd7);
    step();
    check_eq({tag, "_be_we"}, 32'({dmem_we_o, dmem_req_o}), 32'b01);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    #1 check_eq({tag, "_stall_rv"}, 32'(stall_o), 32'd0);
    step();
    drive_idle();
    check_eq({tag, "_wbv"},  32'(wb_valid_o), 32'd1);
    check_eq({tag, "_data"}, wb_data_o, exp);
    check_eq({tag, "_rd"},   32'(wb_rd_o), 32'd7);
  endtask

  // Misaligned or illegal op: no request, error pulse next cycle
  task automatic do_bad(input string tag, input logic rd_op, input logic [2:0] f3, input logic [31:0] addr);
    issue(rd_op, ~rd_op, f3, addr, 32'h5555AAAA, 5'd9);
    #1 check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
    step();
    drive_idle();
    check_eq({tag, "_req"}, 32'(dmem_req_o), 32'd0);
    check_eq({tag, "_err"}, 32'(lsu_err_o), 32'd1);
    check_eq({tag, "_wbv"}, 32'(wb_valid_o), 32'd1);
    check_eq({tag, "_wbrw"}, 32'(wb_reg_write_o), 32'd0);
    step();
    check_eq({tag, "_err_clr"}, 32'(lsu_err_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    dmem_rdata_i = 32'h0;
    drive_idle();
    #12;
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_req",   32'(dmem_req_o), 32'd0);
    check_eq("rst_wbv",   32'(wb_valid_o), 32'd0);
    check_eq("rst_data",  wb_data_o, 32'd0);
    check_eq("rst_err",   32'(lsu_err_o), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // ALU pass-through
    ex_valid_i = 1'b1; ex_alu_result_i = 32'h1234; ex_rd_i = 5'd5; ex_reg_write_i = 1'b1;
    #1 check_eq("add_stall", 32'(stall_o), 32'd0);
    step();
    drive_idle();
    check_eq("add_wbv",  32'(wb_valid_o), 32'd1);
    check_eq("add_data", wb_data_o, 32'h00001234);
    check_eq("add_rd",   32'(wb_rd_o), 32'd5);
    check_eq("add_rw",   32'(wb_reg_write_o), 32'd1);
    step();
    check_eq("add_wbv_pulse", 32'(wb_valid_o), 32'd0);
    check_eq("add_hold", wb_data_o, 32'h00001234);

    do_store("sb", 3'b000, 32'h103, 32'hAABBCCDD, 4'b1000, 32'hDDDDDDDD);
    do_store("sh", 3'b001, 32'h102, 32'h11112222, 4'b1100, 32'h22222222);
    do_store("sw", 3'b010, 32'h104, 32'hCAFEBABE, 4'b1111, 32'hCAFEBABE);

    do_load("lb",  3'b000, 32'h202, 32'h00800000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h202, 32'h00800000, 32'h00000080);
    do_load("lh",  3'b001, 32'h202, 32'h80010000, 32'hFFFF8001);
    do_load("lhu", 3'b101, 32'h202, 32'h80010000, 32'h00008001);
    do_load("lb1", 3'b000, 32'h201, 32'h12345678, 32'h00000056);
    do_load("lw",  3'b010, 32'h304, 32'hCAFEF00D, 32'hCAFEF00D);

    do_bad("lw_mis",  1'b1, 3'b010, 32'h301);
    do_bad("lh_mis",  1'b1, 3'b001, 32'h203);
    do_bad("ld_ill",  1'b1, 3'b011, 32'h300);
    do_bad("st_ill",  1'b0, 3'b011, 32'h300);

    // LW with gnt withheld three cycles, rvalid two cycles after gnt
    wbv_base = wbv_cnt;
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("slow_req",   32'(dmem_req_o), 32'd1);
      check_eq("slow_addr",  dmem_addr_o, 32'h400);
      check_eq("slow_stall", 32'(stall_o), 32'd1);
    end
    step();
    dmem_gnt_i = 1'b1;
    #1 check_eq("slow_gnt_stall", 32'(stall_o), 32'd1);
    step();
    dmem_gnt_i = 1'b0;
    check_eq("slow_wait_req",   32'(dmem_req_o), 32'd0);
    check_eq("slow_wait_stall", 32'(stall_o), 32'd1);
    step();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h13572468;
    #1 check_eq("slow_rv_stall", 32'(stall_o), 32'd0);
    step();
    drive_idle();
    check_eq("slow_data", wb_data_o, 32'h13572468);
    step();
    step();
    check_eq("slow_wbv_count", 32'(wbv_cnt - wbv_base), 32'd1);

    // Reset while waiting for rvalid
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd4);
    step();
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    check_eq("rstw_stall_pre", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstw_stall", 32'(stall_o), 32'd0);
    check_eq("rstw_req",   32'(dmem_req_o), 32'd0);
    step();
    drive_idle();
    rst_n = 1'b1;
    wbv_base = wbv_cnt;
    step();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hDEADBEEF;
    step();
    dmem_rvalid_i = 1'b0;
    check_eq("rstw_wbv", 32'(wb_valid_o), 32'd0);
    step();
    check_eq("rstw_wbv2", 32'(wb_valid_o), 32'd0);
    check_eq("rstw_count", 32'(wbv_cnt - wbv_base), 32'd0);

`ifdef LSU_TIMEOUT_EN
    // gnt never arrives: abort on the 255th REQ cycle
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd6);
    step();
    repeat (253) step();
    check_eq("tmo_stall_254", 32'(stall_o), 32'd1);
    step();
    check_eq("tmo_stall_255", 32'(stall_o), 32'd0);
    step();
    drive_idle();
    check_eq("tmo_req", 32'(dmem_req_o), 32'd0);
    check_eq("tmo_err", 32'(lsu_err_o), 32'd1);
    check_eq("tmo_wbv", 32'(wb_valid_o), 32'd1);
    check_eq("tmo_rw",  32'(wb_reg_write_o), 32'd0);
    step();
    check_eq("tmo_err_clr", 32'(lsu_err_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
